// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// step-counter width and the operand magnitude helper.
package div_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_ZERO
  } state_t;

  // One extra bit so the magnitude of the most-negative operand is exact.
  function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] v);
    logic [DIV_WIDTH:0] ext;
    ext = {v[DIV_WIDTH-1], v};
    return ext[DIV_WIDTH] ? -ext : ext;
  endfunction

endpackage

// File: rtl/div_u_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor magnitude and keep the result if non-negative.
module div_u_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             restore;

  always_comb begin
    rem_sh  = {1'b0, rem_in, quo_in[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvsr};
    // A non-negative trial is always below |divisor|, so bit WIDTH is clear;
    // any set bit in the top two means the subtraction went negative.
    restore = (trial[WIDTH+1:WIDTH] != 2'b00);
    rem_out = restore ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ~restore};
  end

endmodule

// File: rtl/div_s4_seq.sv
// Sequential signed divider: divides magnitudes one restoring step per clock,
// then applies sign correction (truncate toward zero, remainder follows dividend).
module div_s4_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  localparam logic [WIDTH:0] MIN_MAG = {2'b01, {(WIDTH-1){1'b0}}};

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH:0]     dvsr_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               ovf_pend_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;
  logic               ovf_reg;

  logic [WIDTH:0]     mag_a;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign mag_a = abs_ext(dividend);

  div_u_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .dvsr    (dvsr_reg),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      ovf_pend_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // busy still high here means this is the done cycle: drop it, ignore start.
          if (busy_reg) begin
            busy_reg <= 1'b0;
          end else if (start) begin
            quo_reg      <= mag_a[WIDTH-1:0];
            dvsr_reg     <= abs_ext(divisor);
            rem_reg      <= '0;
            cnt_reg      <= '0;
            sign_a_reg   <= dividend[WIDTH-1];
            sign_b_reg   <= divisor[WIDTH-1];
            ovf_pend_reg <= dividend[WIDTH-1] && (mag_a == MIN_MAG) && (&divisor);
            busy_reg     <= 1'b1;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            state_reg    <= (divisor == '0) ? S_ZERO : S_CALC;
          end
        end
        S_CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          quotient_reg  <= (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
          remainder_reg <= sign_a_reg ? -rem_reg : rem_reg;
          ovf_reg       <= ovf_pend_reg;
          done_reg      <= 1'b1;
          state_reg     <= S_IDLE;
        end
        S_ZERO: begin
          // quo_reg still holds |dividend|; rebuild the signed dividend from it.
          quotient_reg  <= '1;
          remainder_reg <= sign_a_reg ? -quo_reg : quo_reg;
          dbz_reg       <= 1'b1;
          done_reg      <= 1'b1;
          state_reg     <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign dbz       = dbz_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_div_s4_seq.sv
// Scoreboard bench for div_s4_seq: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_s4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  logic       ovf;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  div_s4_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        int   ia, ib, ir;
        logic [3:0] recon;
        e = exp_q.pop_front();
        $display("txn %0d / %0d -> q=%h r=%h dbz=%0b ovf=%0b", $signed(e.a), $signed(e.b),
                 quotient, remainder, dbz, ovf);
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("dbz", int'(dbz), int'(e.dbz));
        check("ovf", int'(ovf), int'(e.ovf));
        if (!e.dbz && !e.ovf) begin
          ia    = int'($signed(e.a));
          ib    = int'($signed(e.b));
          ir    = int'($signed(remainder));
          recon = quotient * e.b + remainder;
          check("q_times_d_plus_r", int'(recon), int'(e.a));
          check("rem_smaller_than_divisor",
                int'(((ir < 0) ? -ir : ir) < ((ib < 0) ? -ib : ib)), 1);
          check("rem_sign", int'(ir == 0 || ((ir < 0) == (ia < 0))), 1);
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                      input logic [3:0] r, input logic z, input logic o);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = z; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    check("busy_after_accept", int'(busy), 1);
    check("flags_cleared_on_accept", int'({dbz, ovf}), 0);
  endtask

  // Counts rising edges until done is seen (bounded); 0 means it never came.
  task automatic wait_edge(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    wait_edge(lat);
    check(name, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                     input logic [3:0] r, input logic z, input logic o, input int lat);
    push(a, b, q, r, z, o);
    issue(a, b);
    wait_done(lat, "latency");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ia, ib;
    logic [3:0] a4, b4;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(dbz), 0);
    check("reset_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run(4'd7, 4'd2, 4'h3, 4'h1, 1'b0, 1'b0, 5);
    run(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 5);   // -7 / 2
    run(4'd7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 5);   //  7 / -2
    run(4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0, 5);   // -8 / 3
    run(4'd5, 4'd0, 4'hF, 4'h5, 1'b1, 1'b0, 1);   // divide by zero
    run(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 5);   // -8 / -1 overflow
    run(4'd1, 4'd1, 4'h1, 4'h0, 1'b0, 1'b0, 5);
    run(4'hC, 4'd0, 4'hF, 4'hC, 1'b1, 1'b0, 1);   // -4 / 0
    run(4'd0, 4'd5, 4'h0, 4'h0, 1'b0, 1'b0, 5);

    // start during CALC is ignored: exactly one done for 6/3.
    push(4'd6, 4'd3, 4'h2, 4'h0, 1'b0, 1'b0);
    issue(4'd6, 4'd3);
    @(negedge clk);
    dividend = 4'd3; divisor = 4'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, "latency_repulse");

    // start in the done cycle is ignored.
    push(4'd6, 4'd3, 4'h2, 4'h0, 1'b0, 1'b0);
    issue(4'd6, 4'd3);
    wait_edge(lat);
    check("latency_done_cycle", lat, 5);
    dividend = 4'd1; divisor = 4'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_in_done_ignored", int'(busy), 0);
    repeat (8) @(posedge clk);

    // Reset during CALC step 2 aborts with no done.
    issue(4'd6, 4'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // Every non-zero divisor pair except the overflow case.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        a4 = 4'(ai);
        b4 = 4'(bi);
        if (!(a4 == 4'h8 && b4 == 4'hF)) begin
          ia = int'($signed(a4));
          ib = int'($signed(b4));
          run(a4, b4, 4'(ia / ib), 4'(ia % ib), 1'b0, 1'b0, 5);
        end
      end
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
